// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: run controller placed between the clock/reset source and riscv_top.
// It holds the core in reset for RST_CYCLES ready cycles and then counts run cycles.
// The run ends either on a write to HALT_ADDR or when TIMEOUT_CYCLES is reached.
// Optional heartbeat output: define SIM_RUN_CTRL_HEARTBEAT_EN to enable it.
// With the macro undefined, hb is tied low.
module sim_run_ctrl #(
    parameter int unsigned     RST_CYCLES     = 25,
    parameter int unsigned     CNT_W          = 32,
    parameter longint unsigned TIMEOUT_CYCLES = 64'd1500000000,
    parameter logic [31:0]     HALT_ADDR      = 32'h0003_0004,
    parameter int unsigned     HB_SHIFT       = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy_in,
    input  logic             io_wr,
    input  logic [31:0]      io_addr,
    input  logic [7:0]       io_data,
    output logic             core_rst,
    output logic             running,
    output logic             done,
    output logic             timed_out,
    output logic [7:0]       exit_code,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             hb
);

    localparam int unsigned      HOLD_W       = (RST_CYCLES > 32'd1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(RST_CYCLES - 32'd1);
    localparam logic             TIMEOUT_EN   = (TIMEOUT_CYCLES != 64'd0);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 64'd1) : '0;

    // Reject parameter sets the logic cannot represent.
    if (RST_CYCLES < 32'd1 || HB_SHIFT < 32'd1 || HB_SHIFT > CNT_W) begin : g_param_check
        $error("sim_run_ctrl: RST_CYCLES must be >= 1 and HB_SHIFT must be in 1..CNT_W");
    end

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r,     state_s;
    logic [HOLD_W-1:0] hold_cnt_r,  hold_cnt_s;
    logic              core_rst_r,  core_rst_s;
    logic              running_r,   running_s;
    logic              done_r,      done_s;
    logic              timed_out_r, timed_out_s;
    logic [7:0]        exit_code_r, exit_code_s;
    logic [CNT_W-1:0]  cycle_cnt_r, cycle_cnt_s;
    logic              halt_hit_s;
    logic              tmo_hit_s;

    // State register and registered outputs, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_HOLD;
            hold_cnt_r  <= '0;
            core_rst_r  <= 1'b1;
            running_r   <= 1'b0;
            done_r      <= 1'b0;
            timed_out_r <= 1'b0;
            exit_code_r <= 8'h00;
            cycle_cnt_r <= '0;
        end else begin
            state_r     <= state_s;
            hold_cnt_r  <= hold_cnt_s;
            core_rst_r  <= core_rst_s;
            running_r   <= running_s;
            done_r      <= done_s;
            timed_out_r <= timed_out_s;
            exit_code_r <= exit_code_s;
            cycle_cnt_r <= cycle_cnt_s;
        end
    end

    // Next-state and next-output logic; everything holds while rdy_in is low.
    always_comb begin
        state_s     = state_r;
        hold_cnt_s  = hold_cnt_r;
        core_rst_s  = core_rst_r;
        running_s   = running_r;
        done_s      = done_r;
        timed_out_s = timed_out_r;
        exit_code_s = exit_code_r;
        cycle_cnt_s = cycle_cnt_r;
        halt_hit_s  = io_wr && (io_addr == HALT_ADDR);
        tmo_hit_s   = TIMEOUT_EN && (cycle_cnt_r == TIMEOUT_LAST);
        if (rdy_in) begin
            case (state_r)
                ST_HOLD: begin
                    if (hold_cnt_r == HOLD_LAST) begin
                        state_s    = ST_RUN;
                        core_rst_s = 1'b0;
                        running_s  = 1'b1;
                    end else begin
                        hold_cnt_s = hold_cnt_r + HOLD_W'(1);
                    end
                end
                ST_RUN: begin
                    // The halt write takes priority over a coincident timeout.
                    if (halt_hit_s) begin
                        state_s     = ST_DONE;
                        exit_code_s = io_data;
                        done_s      = 1'b1;
                        running_s   = 1'b0;
                        core_rst_s  = 1'b1;
                    end else if (tmo_hit_s) begin
                        state_s     = ST_DONE;
                        exit_code_s = 8'hFF;
                        timed_out_s = 1'b1;
                        done_s      = 1'b1;
                        running_s   = 1'b0;
                        core_rst_s  = 1'b1;
                    end else begin
                        cycle_cnt_s = cycle_cnt_r + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_s = ST_DONE;
                end
                default: begin
                    state_s    = ST_HOLD;
                    hold_cnt_s = '0;
                    core_rst_s = 1'b1;
                    running_s  = 1'b0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

`ifdef SIM_RUN_CTRL_HEARTBEAT_EN
    logic hb_r;

    // Heartbeat toggles whenever the low HB_SHIFT bits of the run counter are all ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            hb_r <= 1'b0;
        end else if (rdy_in && (state_r == ST_RUN) && (&cycle_cnt_r[HB_SHIFT-1:0])) begin
            hb_r <= ~hb_r;
        end
    end

    assign hb = hb_r;
`else
    assign hb = 1'b0;
`endif

    assign core_rst  = core_rst_r;
    assign running   = running_r;
    assign done      = done_r;
    assign timed_out = timed_out_r;
    assign exit_code = exit_code_r;
    assign cycle_cnt = cycle_cnt_r;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Bench for sim_run_ctrl: two instances share the stimulus.
// Instance 0 keeps the default timeout; instance 1 uses TIMEOUT_CYCLES=50.
// A behavioural model is compared every cycle, and directed literal checks pin the model.
module tb_sim_run_ctrl;

    localparam int              RSTC  = 25;
    localparam int              HBS   = 3;
    localparam longint unsigned TO_A  = 64'd1500000000;
    localparam longint unsigned TO_B  = 64'd50;
    localparam logic [31:0]     HALT  = 32'h0003_0004;

    logic        clk = 1'b0;
    logic        rst, rdy_in, io_wr;
    logic [31:0] io_addr;
    logic [7:0]  io_data;

    logic [1:0]  core_rst_v, running_v, done_v, timed_out_v, hb_v;
    logic [7:0]  exit_v [2];
    logic [31:0] cnt_v  [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Model state, described in terms of run phases rather than RTL state.
    int              m_hold    [2];
    bit              m_started [2];
    bit              m_ended   [2];
    bit              m_to      [2];
    bit              m_hb      [2];
    logic [7:0]      m_exit    [2];
    longint unsigned m_cnt     [2];

    always #5 clk = ~clk;

    sim_run_ctrl #(.RST_CYCLES(RSTC), .CNT_W(32), .TIMEOUT_CYCLES(TO_A),
                   .HALT_ADDR(HALT), .HB_SHIFT(HBS)) dut_a (
        .clk(clk), .rst(rst), .rdy_in(rdy_in), .io_wr(io_wr), .io_addr(io_addr),
        .io_data(io_data), .core_rst(core_rst_v[0]), .running(running_v[0]),
        .done(done_v[0]), .timed_out(timed_out_v[0]), .exit_code(exit_v[0]),
        .cycle_cnt(cnt_v[0]), .hb(hb_v[0])
    );

    sim_run_ctrl #(.RST_CYCLES(RSTC), .CNT_W(32), .TIMEOUT_CYCLES(TO_B),
                   .HALT_ADDR(HALT), .HB_SHIFT(HBS)) dut_b (
        .clk(clk), .rst(rst), .rdy_in(rdy_in), .io_wr(io_wr), .io_addr(io_addr),
        .io_data(io_data), .core_rst(core_rst_v[1]), .running(running_v[1]),
        .done(done_v[1]), .timed_out(timed_out_v[1]), .exit_code(exit_v[1]),
        .cycle_cnt(cnt_v[1]), .hb(hb_v[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step(input int i);
        longint unsigned to_c;
        to_c = (i == 0) ? TO_A : TO_B;
        if (rst) begin
            m_hold[i] = 0; m_started[i] = 1'b0; m_ended[i] = 1'b0; m_to[i] = 1'b0;
            m_hb[i] = 1'b0; m_exit[i] = 8'h00; m_cnt[i] = 64'd0;
        end else if (rdy_in && !m_ended[i]) begin
            if (!m_started[i]) begin
                m_hold[i]++;
                if (m_hold[i] >= RSTC) m_started[i] = 1'b1;
            end else begin
`ifdef SIM_RUN_CTRL_HEARTBEAT_EN
                if ((m_cnt[i] % (64'd1 << HBS)) == ((64'd1 << HBS) - 64'd1)) m_hb[i] = !m_hb[i];
`endif
                if (io_wr && io_addr == HALT) begin
                    m_ended[i] = 1'b1; m_exit[i] = io_data;
                end else if (to_c != 64'd0 && m_cnt[i] == to_c - 64'd1) begin
                    m_ended[i] = 1'b1; m_to[i] = 1'b1; m_exit[i] = 8'hFF;
                end else begin
                    m_cnt[i] = (m_cnt[i] + 64'd1) % (64'd1 << 32);
                end
            end
        end
    endtask

    // Compare every output of both instances against the model on each falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            model_step(i);
            check($sformatf("core_rst%0d", i), core_rst_v[i], !m_started[i] || m_ended[i]);
            check($sformatf("running%0d", i), running_v[i], m_started[i] && !m_ended[i]);
            check($sformatf("done%0d", i), done_v[i], m_ended[i]);
            check($sformatf("timed_out%0d", i), timed_out_v[i], m_to[i]);
            check($sformatf("exit_code%0d", i), exit_v[i], m_exit[i]);
            check($sformatf("cycle_cnt%0d", i), cnt_v[i], m_cnt[i]);
            check($sformatf("hb%0d", i), hb_v[i], m_hb[i]);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        io_wr = 1'b1; io_addr = a; io_data = d;
        cyc(1);
        io_wr = 1'b0; io_addr = 32'h0; io_data = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rdy_in = 1'b1; io_wr = 1'b0; io_addr = 32'h0; io_data = 8'h00;
        cyc(3);
        check("rst_core_rst", core_rst_v, 2'b11);
        check("rst_running", running_v, 2'b00);
        check("rst_cnt", cnt_v[0], 32'd0);
        rst = 1'b0;

        // Reset sequence: core_rst high for 25 cycles, running on the 26th.
        for (int k = 1; k <= 25; k++) begin
            cyc(1);
            check("seq_running", running_v[0], (k == 25) ? 1'b1 : 1'b0);
            check("seq_core_rst", core_rst_v[0], (k < 25) ? 1'b1 : 1'b0);
        end
        check("seq_cnt0", cnt_v[0], 32'd0);

        // Timeout on instance 1 after cycle_cnt reaches 49.
        cyc(49);
        check("pre_to_cnt", cnt_v[1], 32'd49);
        check("pre_to_done", done_v[1], 1'b0);
        cyc(1);
        check("to_done", done_v[1], 1'b1);
        check("to_flag", timed_out_v[1], 1'b1);
        check("to_exit", exit_v[1], 8'hFF);
        check("to_cnt", cnt_v[1], 32'd49);
        check("to_other_cnt", cnt_v[0], 32'd50);

        // Halt on instance 0 after 100 run cycles.
        cyc(50);
        check("pre_halt_cnt", cnt_v[0], 32'd100);
        wr(HALT, 8'h2A);
        check("halt_done", done_v[0], 1'b1);
        check("halt_exit", exit_v[0], 8'h2A);
        check("halt_to", timed_out_v[0], 1'b0);
        check("halt_core_rst", core_rst_v[0], 1'b1);
        check("halt_cnt", cnt_v[0], 32'd100);
        wr(HALT, 8'h11);
        cyc(5);
        check("frozen_exit", exit_v[0], 8'h2A);
        check("frozen_cnt", cnt_v[0], 32'd100);

        // Collision: halt at the timeout cycle; stray write to 0x30000 first.
        do_reset();
        check("rst_after_done", done_v, 2'b00);
        check("rst_after_done_to", timed_out_v[1], 1'b0);
        cyc(25);
        cyc(10);
        wr(32'h0003_0000, 8'h77);
        check("other_addr_done", done_v[0], 1'b0);
        check("other_addr_cnt", cnt_v[0], 32'd11);
        cyc(38);
        check("coll_pre_cnt", cnt_v[1], 32'd49);
        wr(HALT, 8'h5A);
        check("coll_done", done_v[1], 1'b1);
        check("coll_to", timed_out_v[1], 1'b0);
        check("coll_exit", exit_v[1], 8'h5A);

        // rdy_in gap with a dropped halt write, then reset mid-run at cycle 37.
        do_reset();
        cyc(25);
        cyc(20);
        check("gap_pre_cnt", cnt_v[0], 32'd20);
        rdy_in = 1'b0;
        cyc(4);
        wr(HALT, 8'h33);
        cyc(5);
        check("gap_cnt", cnt_v[0], 32'd20);
        check("gap_done", done_v[0], 1'b0);
        rdy_in = 1'b1;
        cyc(17);
        check("mid_cnt", cnt_v[0], 32'd37);
        rst = 1'b1;
        cyc(1);
        check("mid_rst_core_rst", core_rst_v, 2'b11);
        check("mid_rst_running", running_v, 2'b00);
        check("mid_rst_cnt", cnt_v[0], 32'd0);
        rst = 1'b0;
        cyc(24);
        check("rehold_running", running_v[0], 1'b0);
        cyc(1);
        check("rerun_running", running_v[0], 1'b1);
        cyc(50);
        check("re_to_done", done_v[1], 1'b1);
        check("re_to_flag", timed_out_v[1], 1'b1);
        do_reset();
        check("final_done", done_v[1], 1'b0);
        check("final_to", timed_out_v[1], 1'b0);
        check("final_exit", exit_v[1], 8'h00);
`ifndef SIM_RUN_CTRL_HEARTBEAT_EN
        check("hb_off", hb_v, 2'b00);
`endif
        cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
